// File: rtl/pipeline_stall_pkg.sv
// Shared pipeline definitions for the fetch/decode boundary.
package pipeline_stall_pkg;

    // Front-end control states.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } stallState_t;

    // The architectural NOP encodes as all zeros at any instruction width.
    // Slice the low INSTR_W bits from this constant.
    localparam logic [63:0] NOP_WORD = 64'h0;

    // Register-file address width used throughout the pipeline.
    localparam int REG_ADDR_W = 4;

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear. Used for performance-debug counts.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    // A clear request wins over an increment. The count sticks at all-ones.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// IF/ID pipeline register owner: resolves branch flush, memory freeze and
// load-use stall, and drives PC enable and the ID/EX bubble select.
//
// state | meaning
// ------+--------------------------------------------------------------
// RUN   | normal fetch; IF/ID loads every cycle
// STALL | load-use stall in progress; IF/ID and PC held
// FLUSH | post-branch; IF/ID forced invalid while flushCnt counts down
module pipeline_stall_ctrl
    import pipeline_stall_pkg::*;
#(
    parameter int INSTR_W      = 16,
    parameter int PC_W         = 16,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               hazard_stall,
    input  logic               branch_taken,
    input  logic               mem_wait,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [PC_W-1:0]    pc_in,
    input  logic               cnt_clear,
    output logic               pc_write,
    output logic               id_ex_bubble,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [PC_W-1:0]    if_id_pc,
    output logic               if_id_valid,
    output logic [CNT_W-1:0]   stall_count
);

    localparam logic [INSTR_W-1:0] NOP_INSTR  = NOP_WORD[INSTR_W-1:0];
    localparam logic [2:0]         FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    stallState_t state;
    logic [2:0]  flushCnt;
    logic        stallEvent;

    // Enables must react in the same cycle as hazard_stall, so they are combinational.
    always_comb begin
        pc_write     = 1'b1;
        id_ex_bubble = 1'b0;
        if (reset) begin
            pc_write     = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (branch_taken) begin
            pc_write     = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (mem_wait) begin
            pc_write     = 1'b0;
            id_ex_bubble = 1'b0;
        end else if (state == FLUSH) begin
            pc_write     = 1'b1;
            id_ex_bubble = 1'b0;
        end else if (hazard_stall) begin
            pc_write     = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    // A cycle is counted whenever the front end is frozen or stalled.
    // A stall request in FLUSH is ignored because IF/ID already holds nothing.
    always_comb begin
        stallEvent = !branch_taken && (mem_wait || ((state != FLUSH) && hazard_stall));
    end

    // FSM, flush down-counter and IF/ID register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            flushCnt    <= '0;
            if_id_instr <= NOP_INSTR;
            if_id_pc    <= '0;
            if_id_valid <= 1'b0;
        end else if (branch_taken) begin
            state       <= FLUSH;
            flushCnt    <= FLUSH_LOAD;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
        end else if (mem_wait) begin
            // Whole front end frozen: state, counter and IF/ID all hold.
        end else if (state == FLUSH) begin
            if (flushCnt == 3'd0) begin
                // Terminal count: the redirect target fetched this cycle is real.
                state       <= RUN;
                if_id_instr <= instr_in;
                if_id_pc    <= pc_in;
                if_id_valid <= 1'b1;
            end else begin
                flushCnt    <= flushCnt - 3'd1;
                if_id_instr <= NOP_INSTR;
                if_id_valid <= 1'b0;
            end
        end else if (hazard_stall) begin
            state <= STALL;
        end else begin
            state       <= RUN;
            if_id_instr <= instr_in;
            if_id_pc    <= pc_in;
            if_id_valid <= 1'b1;
        end
    end

    sat_counter #(
        .WIDTH(CNT_W)
    ) uStallCounter (
        .clock(clock),
        .reset(reset),
        .inc  (stallEvent),
        .clear(cnt_clear),
        .count(stall_count)
    );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl with FLUSH_CYCLES=2 and a 4-bit stall counter.
module tb_pipeline_stall_ctrl;

    logic        clock;
    logic        reset;
    logic        hazard_stall;
    logic        branch_taken;
    logic        mem_wait;
    logic [15:0] instr_in;
    logic [15:0] pc_in;
    logic        cnt_clear;
    logic        pc_write;
    logic        id_ex_bubble;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc;
    logic        if_id_valid;
    logic [3:0]  stall_count;

    int checks = 0;
    int errors = 0;

    pipeline_stall_ctrl #(
        .INSTR_W(16), .PC_W(16), .FLUSH_CYCLES(2), .CNT_W(4)
    ) dut (
        .clock(clock), .reset(reset), .hazard_stall(hazard_stall),
        .branch_taken(branch_taken), .mem_wait(mem_wait), .instr_in(instr_in),
        .pc_in(pc_in), .cnt_clear(cnt_clear), .pc_write(pc_write),
        .id_ex_bubble(id_ex_bubble), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
        .if_id_valid(if_id_valid), .stall_count(stall_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        h, b, m, c;
        logic [15:0] instr, pc;
        logic        ePw, eBub, eValid;
        logic [15:0] eInstr, ePc;
        logic [3:0]  eCnt;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(logic h, logic b, logic m, logic c,
                                logic [15:0] instr, logic [15:0] pc,
                                logic ePw, logic eBub, logic eValid,
                                logic [15:0] eInstr, logic [15:0] ePc, logic [3:0] eCnt);
        vec_t v;
        v.h = h; v.b = b; v.m = m; v.c = c; v.instr = instr; v.pc = pc;
        v.ePw = ePw; v.eBub = eBub; v.eValid = eValid;
        v.eInstr = eInstr; v.ePc = ePc; v.eCnt = eCnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic h, input logic b, input logic m, input logic c,
                         input logic [15:0] instr, input logic [15:0] pc);
        hazard_stall = h; branch_taken = b; mem_wait = m; cnt_clear = c;
        instr_in = instr; pc_in = pc;
    endtask

    // Drive after the falling edge, check enables before the rising edge,
    // check registered outputs just after it.
    task automatic applyVec(input vec_t v, input string tag);
        @(negedge clock);
        drive(v.h, v.b, v.m, v.c, v.instr, v.pc);
        #1;
        check({tag, " pc_write"}, 32'(pc_write), 32'(v.ePw));
        check({tag, " id_ex_bubble"}, 32'(id_ex_bubble), 32'(v.eBub));
        @(posedge clock);
        #1;
        check({tag, " if_id_valid"}, 32'(if_id_valid), 32'(v.eValid));
        check({tag, " if_id_instr"}, 32'(if_id_instr), 32'(v.eInstr));
        check({tag, " if_id_pc"}, 32'(if_id_pc), 32'(v.ePc));
        check({tag, " stall_count"}, 32'(stall_count), 32'(v.eCnt));
    endtask

    initial begin
        //           h  b  m  c  instr     pc      pw bub val eInstr    ePc     cnt
        vecs[0]  = mk(0, 0, 0, 0, 16'h1234, 16'd0,  1, 0, 1, 16'h1234, 16'd0,  4'd0);
        vecs[1]  = mk(0, 0, 0, 0, 16'h2345, 16'd1,  1, 0, 1, 16'h2345, 16'd1,  4'd0);
        vecs[2]  = mk(1, 0, 0, 0, 16'h3456, 16'd2,  0, 1, 1, 16'h2345, 16'd1,  4'd1);
        vecs[3]  = mk(0, 0, 0, 0, 16'h3456, 16'd2,  1, 0, 1, 16'h3456, 16'd2,  4'd1);
        vecs[4]  = mk(0, 0, 0, 0, 16'h4567, 16'd3,  1, 0, 1, 16'h4567, 16'd3,  4'd1);
        vecs[5]  = mk(1, 1, 0, 0, 16'h5678, 16'd4,  1, 1, 0, 16'h0000, 16'd3,  4'd1);
        vecs[6]  = mk(1, 0, 0, 0, 16'h9000, 16'd10, 1, 0, 0, 16'h0000, 16'd3,  4'd1);
        vecs[7]  = mk(1, 0, 0, 0, 16'h9001, 16'd11, 1, 0, 1, 16'h9001, 16'd11, 4'd1);
        vecs[8]  = mk(0, 0, 0, 0, 16'h9002, 16'd12, 1, 0, 1, 16'h9002, 16'd12, 4'd1);
        vecs[9]  = mk(1, 0, 1, 0, 16'haaaa, 16'd20, 0, 0, 1, 16'h9002, 16'd12, 4'd2);
        vecs[10] = mk(1, 0, 1, 0, 16'haaab, 16'd21, 0, 0, 1, 16'h9002, 16'd12, 4'd3);
        vecs[11] = mk(1, 1, 1, 0, 16'haaac, 16'd22, 1, 1, 0, 16'h0000, 16'd12, 4'd3);
        vecs[12] = mk(1, 0, 1, 0, 16'haaad, 16'd23, 0, 0, 0, 16'h0000, 16'd12, 4'd4);
        vecs[13] = mk(1, 0, 0, 0, 16'hbbbb, 16'd30, 1, 0, 0, 16'h0000, 16'd12, 4'd4);
        vecs[14] = mk(0, 0, 0, 0, 16'hcccc, 16'd31, 1, 0, 1, 16'hcccc, 16'd31, 4'd4);

        reset = 1'b1;
        drive(0, 0, 0, 0, 16'h0, 16'h0);
        #2;
        check("reset pc_write", 32'(pc_write), 32'd0);
        check("reset id_ex_bubble", 32'(id_ex_bubble), 32'd1);
        check("reset if_id_valid", 32'(if_id_valid), 32'd0);
        check("reset if_id_instr", 32'(if_id_instr), 32'd0);
        check("reset if_id_pc", 32'(if_id_pc), 32'd0);
        check("reset stall_count", 32'(stall_count), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            applyVec(vecs[i], $sformatf("vec%0d", i));
        end

        // Twenty back-to-back load-use stalls: counter climbs from 4 and sticks at 15.
        for (int i = 0; i < 20; i++) begin
            applyVec(mk(1, 0, 0, 0, 16'hdead, 16'd50, 0, 1, 1, 16'hcccc, 16'd31,
                        (4 + i + 1 > 15) ? 4'd15 : 4'(4 + i + 1)), $sformatf("sat%0d", i));
        end
        applyVec(mk(1, 0, 0, 1, 16'hdead, 16'd50, 0, 1, 1, 16'hcccc, 16'd31, 4'd0), "clear");
        applyVec(mk(1, 0, 0, 0, 16'hdead, 16'd50, 0, 1, 1, 16'hcccc, 16'd31, 4'd1), "post_clear");

        // Take a branch, then hit reset between edges while in FLUSH.
        applyVec(mk(0, 1, 0, 0, 16'h7777, 16'd60, 1, 1, 0, 16'h0000, 16'd31, 4'd1), "pre_rst_branch");
        #2;
        reset = 1'b1;
        #1;
        check("midrst pc_write", 32'(pc_write), 32'd0);
        check("midrst id_ex_bubble", 32'(id_ex_bubble), 32'd1);
        check("midrst if_id_valid", 32'(if_id_valid), 32'd0);
        check("midrst if_id_instr", 32'(if_id_instr), 32'd0);
        check("midrst if_id_pc", 32'(if_id_pc), 32'd0);
        check("midrst stall_count", 32'(stall_count), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        drive(0, 0, 0, 0, 16'hdddd, 16'd40);
        #1;
        check("postrst pc_write", 32'(pc_write), 32'd1);
        check("postrst id_ex_bubble", 32'(id_ex_bubble), 32'd0);
        @(posedge clock);
        #1;
        check("postrst if_id_valid", 32'(if_id_valid), 32'd1);
        check("postrst if_id_instr", 32'(if_id_instr), 32'hdddd);
        check("postrst if_id_pc", 32'(if_id_pc), 32'd40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
